pipe_phy_loopback_model: RTL and testbench

// - Synthesizable PHY-side PIPE responder that sits directly below the PCIe MAC/LTSSM top; consumes its Tx PIPE outputs, produces its Rx PIPE inputs.
// - Answers receiver detect, rate change and PowerDown requests with PhyStatus/RxStatus handshakes.
// - Loops Tx data back to Rx through a fixed-latency pipeline, replacing ad-hoc bench stimulus for link-up and data-path tests.

---
 rtl/pcie_phy_model_pkg.sv | 29 ++
 rtl/pipe_delay_line.sv | 33 +++
 rtl/pipe_phy_loopback_model.sv | 183 ++++++++++++++++++
 tb/tb_pipe_phy_loopback_model.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_model_pkg.sv
// Shared definitions for the PIPE PHY loopback responder.
//   - phy_state_e        : handshake FSM states
//   - RXSTATUS_DETECTED  : RxStatus code reported for a present receiver
//   - PD_P0 / PD_P1      : PowerDown encodings for active and reset-default states
//   - CNT_W / latLoad()  : latency down-counter width and entry value helper
package pcie_phy_model_pkg;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_IDLE  = 3'd1,
    S_DET   = 3'd2,
    S_DWAIT = 3'd3,
    S_RATE  = 3'd4,
    S_PD    = 3'd5
  } phy_state_e;

  localparam logic [2:0] RXSTATUS_DETECTED = 3'b011;
  localparam logic [3:0] PD_P0             = 4'd0;
  localparam logic [3:0] PD_P1             = 4'd2;

  localparam int unsigned CNT_W = 16;

  // The counter fires on the edge it is seen at zero, so a latency of N
  // cycles is loaded as N-1. Zero latencies are not supported.
  function automatic logic [CNT_W-1:0] latLoad(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/pipe_delay_line.sv
// Resettable fixed-depth shift register used to delay the Tx bundle to Rx.
//   CLK     in  clock, rising edge
//   reset   in  synchronous active-low reset, clears every stage
//   dataIn  in  WIDTH bits captured each cycle
//   dataOut out dataIn delayed by exactly DEPTH cycles
module pipe_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= dataIn;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dataOut = stage_q[DEPTH-1];

endmodule

// File: rtl/pipe_phy_loopback_model.sv
// PHY-side PIPE responder placed directly below a PCIe MAC/LTSSM.
// Answers receiver detect, rate change and PowerDown requests with PhyStatus /
// RxStatus handshakes and loops Tx data back to Rx through a fixed pipeline.
//
// Ports
//   CLK, reset (sync, active-low)
//   Tx side  : TxData, TxDataValid, TxDataK, TxStartBlock, TxSyncHeader, TxElecIdle,
//              TxDetectRx_Loopback, PowerDown (lane 0 field used), Rate
//   Rx side  : RxData, RxDataValid, RxDataK, RxStartBlock, RxSyncHeader (looped data),
//              RxValid, RxStatus, RxElectricalIdle, PhyStatus (identical on all lanes)
//
// Configuration macro PHY_RXELECIDLE_EN: when defined RxElectricalIdle follows the
// delayed TxElecIdle (all ones outside P0); otherwise it is tied to 0.
module pipe_phy_loopback_model
  import pcie_phy_model_pkg::*;
#(
  parameter int unsigned MAXPIPEWIDTH  = 32,
  parameter int unsigned LANESNUMBER   = 16,
  parameter int unsigned PHY_RESET_CYC = 4,
  parameter int unsigned DETECT_LAT    = 4,
  parameter int unsigned RATE_LAT      = 8,
  parameter int unsigned PD_LAT        = 2,
  parameter int unsigned LOOPBACK_LAT  = 2,
  parameter logic [LANESNUMBER-1:0] RX_PRESENT = '1
) (
  input  logic                                    CLK,
  input  logic                                    reset,
  input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]     TxData,
  input  logic [LANESNUMBER-1:0]                  TxDataValid,
  input  logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] TxDataK,
  input  logic [LANESNUMBER-1:0]                  TxStartBlock,
  input  logic [2*LANESNUMBER-1:0]                TxSyncHeader,
  input  logic [LANESNUMBER-1:0]                  TxElecIdle,
  input  logic [LANESNUMBER-1:0]                  TxDetectRx_Loopback,
  input  logic [4*LANESNUMBER-1:0]                PowerDown,
  input  logic [3:0]                              Rate,
  output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]     RxData,
  output logic [LANESNUMBER-1:0]                  RxDataValid,
  output logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] RxDataK,
  output logic [LANESNUMBER-1:0]                  RxStartBlock,
  output logic [2*LANESNUMBER-1:0]                RxSyncHeader,
  output logic [LANESNUMBER-1:0]                  RxValid,
  output logic [3*LANESNUMBER-1:0]                RxStatus,
  output logic [LANESNUMBER-1:0]                  RxElectricalIdle,
  output logic [LANESNUMBER-1:0]                  PhyStatus
);

  localparam int unsigned DataW = MAXPIPEWIDTH * LANESNUMBER;
  localparam int unsigned KW    = (MAXPIPEWIDTH / 8) * LANESNUMBER;
`ifdef PHY_RXELECIDLE_EN
  localparam int unsigned BundleW = DataW + KW + 5 * LANESNUMBER;
`else
  localparam int unsigned BundleW = DataW + KW + 4 * LANESNUMBER;
`endif

  phy_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       rate_q;
  logic [3:0]       pd_q;

  logic                      detReq;
  logic [3*LANESNUMBER-1:0]  detStatus;
  logic [BundleW-1:0]        txBundle;
  logic [BundleW-1:0]        rxBundle;
  logic [LANESNUMBER-1:0]    dlyValid;
  logic                      rxGate;

  // Only lane 0 carries the authoritative PowerDown request.
  logic unusedPowerDown;
  assign unusedPowerDown = ^PowerDown[4*LANESNUMBER-1:4];

  assign detReq = |(TxDetectRx_Loopback & TxElecIdle);

  always_comb begin
    detStatus = '0;
    for (int unsigned i = 0; i < LANESNUMBER; i++) begin
      if (RX_PRESENT[i]) begin
        detStatus[3*i +: 3] = RXSTATUS_DETECTED;
      end
    end
  end

  // Handshake FSM. PhyStatus/RxStatus are registered and default to 0 so every
  // completion is a single-cycle pulse; reset aborts any pending handshake.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q   <= S_RST;
      cnt_q     <= latLoad(PHY_RESET_CYC);
      rate_q    <= '0;
      pd_q      <= PD_P1;
      PhyStatus <= '1;
      RxStatus  <= '0;
    end else begin
      PhyStatus <= '0;
      RxStatus  <= '0;
      unique case (state_q)
        S_RST: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            PhyStatus <= '1;
            cnt_q     <= cnt_q - 1'b1;
          end
        end
        S_IDLE: begin
          // Losing requests stay visible as input/register mismatches.
          if (detReq) begin
            state_q <= S_DET;
            cnt_q   <= latLoad(DETECT_LAT);
          end else if (Rate != rate_q) begin
            state_q <= S_RATE;
            cnt_q   <= latLoad(RATE_LAT);
          end else if (PowerDown[3:0] != pd_q) begin
            state_q <= S_PD;
            cnt_q   <= latLoad(PD_LAT);
          end
        end
        S_DET: begin
          if (cnt_q == '0) begin
            PhyStatus <= '1;
            RxStatus  <= detStatus;
            state_q   <= S_DWAIT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DWAIT: begin
          // Wait for the request to drop so a held request does not retrigger.
          if (TxDetectRx_Loopback == '0) begin
            state_q <= S_IDLE;
          end
        end
        S_RATE: begin
          if (cnt_q == '0) begin
            rate_q    <= Rate;
            PhyStatus <= '1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_PD: begin
          if (cnt_q == '0) begin
            pd_q      <= PowerDown[3:0];
            PhyStatus <= '1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef PHY_RXELECIDLE_EN
  logic [LANESNUMBER-1:0] rxElecIdleDly;
  assign txBundle = {TxElecIdle, TxSyncHeader, TxStartBlock, TxDataK, TxDataValid, TxData};
  assign {rxElecIdleDly, RxSyncHeader, RxStartBlock, RxDataK, dlyValid, RxData} = rxBundle;
  assign RxElectricalIdle = (pd_q != PD_P0) ? '1 : rxElecIdleDly;
`else
  assign txBundle = {TxSyncHeader, TxStartBlock, TxDataK, TxDataValid, TxData};
  assign {RxSyncHeader, RxStartBlock, RxDataK, dlyValid, RxData} = rxBundle;
  assign RxElectricalIdle = '0;
`endif

  pipe_delay_line #(
    .WIDTH (BundleW),
    .DEPTH (LOOPBACK_LAT)
  ) u_delay (
    .CLK     (CLK),
    .reset   (reset),
    .dataIn  (txBundle),
    .dataOut (rxBundle)
  );

  // Data keeps flowing through the pipeline; only the valid qualifiers are
  // suppressed outside P0 and while a rate change is in progress.
  assign rxGate      = (pd_q == PD_P0) && (state_q != S_RATE);
  assign RxDataValid = dlyValid & {LANESNUMBER{rxGate}};
  assign RxValid     = dlyValid & {LANESNUMBER{rxGate}};

endmodule

// File: tb/tb_pipe_phy_loopback_model.sv
module tb_pipe_phy_loopback_model;

  localparam int L    = 16;
  localparam int W    = 32;
  localparam int KW   = 64;
  localparam int LAT  = 2;
  localparam int PRST = 4;
  localparam int DLAT = 4;
  localparam int RLAT = 8;
  localparam int PLAT = 2;
  localparam logic [L-1:0] RXP = 16'h00FF;

  logic           CLK = 1'b0;
  logic           reset = 1'b0;
  logic [W*L-1:0] TxData = '0;
  logic [L-1:0]   TxDataValid = '0;
  logic [KW-1:0]  TxDataK = '0;
  logic [L-1:0]   TxStartBlock = '0;
  logic [2*L-1:0] TxSyncHeader = '0;
  logic [L-1:0]   TxElecIdle = '0;
  logic [L-1:0]   TxDetectRx_Loopback = '0;
  logic [4*L-1:0] PowerDown = {16{4'd2}};
  logic [3:0]     Rate = 4'd0;
  logic [W*L-1:0] RxData;
  logic [L-1:0]   RxDataValid;
  logic [KW-1:0]  RxDataK;
  logic [L-1:0]   RxStartBlock;
  logic [2*L-1:0] RxSyncHeader;
  logic [L-1:0]   RxValid;
  logic [3*L-1:0] RxStatus;
  logic [L-1:0]   RxElectricalIdle;
  logic [L-1:0]   PhyStatus;

  pipe_phy_loopback_model #(
    .MAXPIPEWIDTH (W), .LANESNUMBER (L), .PHY_RESET_CYC (PRST), .DETECT_LAT (DLAT),
    .RATE_LAT (RLAT), .PD_LAT (PLAT), .LOOPBACK_LAT (LAT), .RX_PRESENT (RXP)
  ) dut (
    .CLK (CLK), .reset (reset), .TxData (TxData), .TxDataValid (TxDataValid),
    .TxDataK (TxDataK), .TxStartBlock (TxStartBlock), .TxSyncHeader (TxSyncHeader),
    .TxElecIdle (TxElecIdle), .TxDetectRx_Loopback (TxDetectRx_Loopback),
    .PowerDown (PowerDown), .Rate (Rate), .RxData (RxData), .RxDataValid (RxDataValid),
    .RxDataK (RxDataK), .RxStartBlock (RxStartBlock), .RxSyncHeader (RxSyncHeader),
    .RxValid (RxValid), .RxStatus (RxStatus), .RxElectricalIdle (RxElectricalIdle),
    .PhyStatus (PhyStatus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a handshake is "busy until cycle m_fire"; data is a FIFO
  // of the last LAT Tx bundles.
  typedef enum {M_RST, M_IDLE, M_DET, M_HOLD, M_RATE, M_PD} mode_t;
  typedef struct packed {
    logic [W*L-1:0] d;
    logic [L-1:0]   v;
    logic [KW-1:0]  k;
    logic [L-1:0]   sb;
    logic [2*L-1:0] sh;
    logic [L-1:0]   ei;
  } bundle_t;

  mode_t          m_mode = M_RST;
  int             m_cyc  = 0;
  int             m_fire = 0;
  logic [3:0]     m_rate = '0;
  logic [3:0]     m_pd   = 4'd2;
  logic [L-1:0]   m_phy  = '1;
  logic [3*L-1:0] m_rxst = '0;
  logic [3*L-1:0] det_exp;
  bundle_t        m_pipe[$];

  function automatic logic [3*L-1:0] detect_status();
    logic [3*L-1:0] s = '0;
    for (int i = 0; i < L; i++) if (RXP[i]) s[3*i +: 3] = 3'b011;
    return s;
  endfunction

  task automatic model_step();
    bundle_t b;
    bundle_t dummy;
    m_cyc++;
    if (!reset) begin
      m_mode = M_RST; m_fire = m_cyc + PRST; m_phy = '1; m_rxst = '0;
      m_rate = '0; m_pd = 4'd2;
      m_pipe.delete();
      for (int i = 0; i < LAT; i++) m_pipe.push_back('0);
      return;
    end
    b.d = TxData; b.v = TxDataValid; b.k = TxDataK; b.sb = TxStartBlock;
    b.sh = TxSyncHeader; b.ei = TxElecIdle;
    m_pipe.push_back(b);
    dummy = m_pipe.pop_front();
    m_phy = '0; m_rxst = '0;
    case (m_mode)
      M_RST: if (m_cyc == m_fire) m_mode = M_IDLE; else m_phy = '1;
      M_IDLE: begin
        if (|(TxDetectRx_Loopback & TxElecIdle)) begin
          m_mode = M_DET; m_fire = m_cyc + DLAT;
        end else if (Rate != m_rate) begin
          m_mode = M_RATE; m_fire = m_cyc + RLAT;
        end else if (PowerDown[3:0] != m_pd) begin
          m_mode = M_PD; m_fire = m_cyc + PLAT;
        end
      end
      M_DET: if (m_cyc == m_fire) begin
        m_phy = '1; m_rxst = detect_status(); m_mode = M_HOLD;
      end
      M_HOLD: if (TxDetectRx_Loopback == '0) m_mode = M_IDLE;
      M_RATE: if (m_cyc == m_fire) begin
        m_rate = Rate; m_phy = '1; m_mode = M_IDLE;
      end
      M_PD: if (m_cyc == m_fire) begin
        m_pd = PowerDown[3:0]; m_phy = '1; m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [L-1:0] exp_valid();
    return (m_pd == 4'd0 && m_mode != M_RATE) ? m_pipe[0].v : '0;
  endfunction

  function automatic logic [L-1:0] exp_eidle();
`ifdef PHY_RXELECIDLE_EN
    return (m_pd != 4'd0) ? '1 : m_pipe[0].ei;
`else
    return '0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [L-1:0] e;
    reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (PhyStatus !== 16'hFFFF) $display("FAIL reset_phystatus got=%h exp=ffff", PhyStatus);
    else n_pass++;
    n_checks++;
    if (RxStatus !== '0 || RxValid !== '0 || RxData !== '0 || RxElectricalIdle !== '0)
      $display("FAIL reset_outputs_zero rxst=%h rxv=%h eidle=%h", RxStatus, RxValid,
               RxElectricalIdle);
    else n_pass++;
    reset = 1'b1;
    for (int i = 0; i <= PRST; i++) begin
      if (i > 0) tick();
      e = (i < PRST) ? 16'hFFFF : 16'h0000;
      n_checks++;
      if (PhyStatus !== e || PhyStatus !== m_phy)
        $display("FAIL release_phystatus i=%0d got=%h exp=%h", i, PhyStatus, e);
      else n_pass++;
    end
    n_checks++;
    if (RxStatus !== '0) $display("FAIL release_rxstatus got=%h exp=0", RxStatus);
    else n_pass++;
  endtask

  task automatic test_detect();
    logic pulse;
    TxElecIdle = '1;
    TxDetectRx_Loopback = 16'hFFFF;
    for (int i = 1; i <= 10; i++) begin
      tick();
      pulse = (i == DLAT + 1);
      n_checks++;
      if (PhyStatus !== (pulse ? 16'hFFFF : 16'h0000) || PhyStatus !== m_phy)
        $display("FAIL detect_phystatus i=%0d got=%h exp_pulse=%0d", i, PhyStatus, pulse);
      else n_pass++;
      n_checks++;
      if (RxStatus !== (pulse ? det_exp : '0))
        $display("FAIL detect_rxstatus i=%0d got=%h exp=%h", i, RxStatus,
                 pulse ? det_exp : '0);
      else n_pass++;
    end
    TxDetectRx_Loopback = '0;
    TxElecIdle = '0;
    tick();
    n_checks++;
    if (PhyStatus !== '0) $display("FAIL detect_release got=%h exp=0", PhyStatus);
    else n_pass++;
  endtask

  task automatic test_pd_rate();
    logic [L-1:0] ep;
    logic [L-1:0] ev;
    TxDataValid = '1;
    repeat (2) tick();
    PowerDown = '0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 1) Rate = 4'd1;
      ep = (i == PLAT + 1 || i == PLAT + RLAT + 2) ? 16'hFFFF : 16'h0000;
      ev = (i == PLAT + 1 || i >= PLAT + RLAT + 2) ? 16'hFFFF : 16'h0000;
      n_checks++;
      if (PhyStatus !== ep || PhyStatus !== m_phy)
        $display("FAIL pdrate_phystatus i=%0d got=%h exp=%h", i, PhyStatus, ep);
      else n_pass++;
      n_checks++;
      if (RxValid !== ev || RxDataValid !== exp_valid())
        $display("FAIL pdrate_rxvalid i=%0d got=%h exp=%h", i, RxValid, ev);
      else n_pass++;
    end
  endtask

  task automatic test_loopback();
    for (int w = 0; w < L; w++) TxData[w*W +: W] = $urandom;
    TxData[31:0] = 32'hA5A5_0F0F;
    TxDataValid = 16'($urandom) | 16'h0001;
    tick();
    TxData = '0;
    TxDataValid = '0;
    n_checks++;
    if (RxData !== m_pipe[0].d) $display("FAIL loop_stage1 got=%h exp=%h", RxData[31:0],
                                         m_pipe[0].d[31:0]);
    else n_pass++;
    tick();
    n_checks++;
    if (RxData[31:0] !== 32'hA5A5_0F0F || RxValid[0] !== 1'b1 || RxDataValid[0] !== 1'b1)
      $display("FAIL loop_lane0 got=%h rxv=%b exp=a5a50f0f rxv=1", RxData[31:0], RxValid[0]);
    else n_pass++;
    tick();
    n_checks++;
    if (RxData[31:0] !== 32'h0 || RxValid !== '0)
      $display("FAIL loop_drain got=%h rxv=%h exp=0", RxData[31:0], RxValid);
    else n_pass++;
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 400; c++) begin
      for (int w = 0; w < L; w++) TxData[w*W +: W] = $urandom;
      TxDataValid  = 16'($urandom);
      TxDataK      = {$urandom, $urandom};
      TxStartBlock = 16'($urandom);
      TxSyncHeader = $urandom;
      TxElecIdle   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : '1;
      if (hold > 0) begin
        hold--;
        if (hold == 0) TxDetectRx_Loopback = '0;
      end else if ($urandom_range(0, 29) == 0) begin
        TxDetectRx_Loopback = 16'($urandom) | 16'h0001;
        hold = $urandom_range(1, 8);
      end
      if ($urandom_range(0, 24) == 0) Rate = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 24) == 0) begin
        PowerDown = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0, 1:    PowerDown[3:0] = 4'd0;
          2:       PowerDown[3:0] = 4'd2;
          default: PowerDown[3:0] = 4'd3;
        endcase
      end
      tick();
      n_checks++;
      if (PhyStatus !== m_phy)
        $display("FAIL rand_phystatus cyc=%0d got=%h exp=%h", m_cyc, PhyStatus, m_phy);
      else n_pass++;
      n_checks++;
      if (RxStatus !== m_rxst)
        $display("FAIL rand_rxstatus cyc=%0d got=%h exp=%h", m_cyc, RxStatus, m_rxst);
      else n_pass++;
      n_checks++;
      if (RxData !== m_pipe[0].d)
        $display("FAIL rand_rxdata cyc=%0d got=%h exp=%h", m_cyc, RxData, m_pipe[0].d);
      else n_pass++;
      n_checks++;
      if (RxValid !== exp_valid() || RxDataValid !== exp_valid())
        $display("FAIL rand_valid cyc=%0d got=%h/%h exp=%h", m_cyc, RxValid, RxDataValid,
                 exp_valid());
      else n_pass++;
      n_checks++;
      if (RxDataK !== m_pipe[0].k || RxStartBlock !== m_pipe[0].sb ||
          RxSyncHeader !== m_pipe[0].sh)
        $display("FAIL rand_ctrl cyc=%0d got=%h/%h/%h exp=%h/%h/%h", m_cyc, RxDataK,
                 RxStartBlock, RxSyncHeader, m_pipe[0].k, m_pipe[0].sb, m_pipe[0].sh);
      else n_pass++;
      n_checks++;
      if (RxElectricalIdle !== exp_eidle())
        $display("FAIL rand_eidle cyc=%0d got=%h exp=%h", m_cyc, RxElectricalIdle,
                 exp_eidle());
      else n_pass++;
    end
    TxDetectRx_Loopback = '0;
  endtask

  task automatic test_reset_mid_rate();
    bit settled = 1'b0;
    logic [L-1:0] ep;
    for (int i = 0; i < 60 && !settled; i++) begin
      tick();
      settled = (m_mode == M_IDLE) && (Rate == m_rate) && (PowerDown[3:0] == m_pd);
    end
    n_checks++;
    if (!settled) $display("FAIL settle_timeout mode=%0d", m_mode);
    else n_pass++;
    Rate = (m_rate == 4'd1) ? 4'd2 : 4'd1;
    TxDataValid = '1;
    for (int w = 0; w < L; w++) TxData[w*W +: W] = $urandom | 32'h1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (PhyStatus !== 16'hFFFF || RxData !== '0 || RxValid !== '0)
      $display("FAIL midreset_flush phy=%h rxd0=%h rxv=%h", PhyStatus, RxData[31:0], RxValid);
    else n_pass++;
    reset = 1'b1;
    for (int i = 1; i <= PRST + RLAT + 1; i++) begin
      tick();
      // Rate request is still pending against the cleared rate register.
      ep = (i < PRST || i == PRST + RLAT + 1) ? 16'hFFFF : 16'h0000;
      n_checks++;
      if (PhyStatus !== ep || PhyStatus !== m_phy)
        $display("FAIL midreset_phystatus i=%0d got=%h exp=%h", i, PhyStatus, ep);
      else n_pass++;
    end
  endtask

  initial begin
    det_exp = detect_status();
    test_reset();
    test_detect();
    test_pd_rate();
    test_loopback();
    test_random();
    test_reset_mid_rate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
